// File: rtl/clint_timer_pkg.sv
// Shared constants and address decode for the core-local interruptor timer block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: register offsets, mtimecmp reset value, register-select enum, decode helper.
package clint_timer_pkg;

   localparam logic [15:0] MSIP_OFF        = 16'h0000;
   localparam logic [15:0] MTIMECMP_LO_OFF = 16'h4000;
   localparam logic [15:0] MTIMECMP_HI_OFF = 16'h4004;
   localparam logic [15:0] MTIME_LO_OFF    = 16'hBFF8;
   localparam logic [15:0] MTIME_HI_OFF    = 16'hBFFC;

   // Compare-value reset keeps the timer interrupt quiet until software arms it.
   localparam logic [63:0] MTIMECMP_RST    = 64'hFFFF_FFFF_FFFF_FFFF;

   typedef enum logic [2:0] {
      SEL_NONE,
      SEL_MSIP,
      SEL_CMP_LO,
      SEL_CMP_HI,
      SEL_TIME_LO,
      SEL_TIME_HI
   } reg_sel_e;

   // Word-granular decode: the two byte-offset bits are masked off.
   function automatic reg_sel_e decode_addr(input logic [15:0] addr);
      logic [15:0] word;
      reg_sel_e    sel;
      word = addr & 16'hFFFC;
      sel  = SEL_NONE;
      if (word == MSIP_OFF)             sel = SEL_MSIP;
      else if (word == MTIMECMP_LO_OFF) sel = SEL_CMP_LO;
      else if (word == MTIMECMP_HI_OFF) sel = SEL_CMP_HI;
      else if (word == MTIME_LO_OFF)    sel = SEL_TIME_LO;
      else if (word == MTIME_HI_OFF)    sel = SEL_TIME_HI;
      return sel;
   endfunction

endpackage

// File: rtl/clint_timer_if.sv
// Register-access bus between a requester and the timer block.
// Latency: response strobe exactly one cycle after each request.
// Backpressure: none; every request is accepted, no wait states.
// Signals: bus_req/bus_we/bus_addr/bus_wdata (request), bus_ack/bus_rdata/bus_err (response).
interface clint_timer_if;

   logic        bus_req;
   logic        bus_we;
   logic [15:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;
   logic        bus_err;

   modport master (
      output bus_req,
      output bus_we,
      output bus_addr,
      output bus_wdata,
      input  bus_ack,
      input  bus_rdata,
      input  bus_err
   );

   modport slave (
      input  bus_req,
      input  bus_we,
      input  bus_addr,
      input  bus_wdata,
      output bus_ack,
      output bus_rdata,
      output bus_err
   );

endinterface

// File: rtl/clint_tick_gen.sv
// Prescaler producing one mtime tick every TICK_DIV clk cycles.
// Latency: tick is combinational from the counter; restart takes effect at the next edge.
// Backpressure: none.
// Ports: clk, cpurst (sync active-high), restart (zero the count), tick (one-cycle strobe).
module clint_tick_gen #(
   parameter int unsigned TICK_DIV = 1
) (
   input  logic clk,
   input  logic cpurst,
   input  logic restart,
   output logic tick
);

   localparam logic [15:0] LAST = 16'(TICK_DIV - 1);

   logic [15:0] cnt;

   // With TICK_DIV=1 the counter sits at 0 and tick is high every cycle.
   assign tick = (cnt == LAST);

   always_ff @(posedge clk) begin
      if (cpurst || restart || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 16'd1;
      end
   end

endmodule

// File: rtl/clint_timer.sv
// Machine timer/software-interrupt block: 64-bit mtime, mtimecmp, msip, bus-mapped.
// Latency: one-cycle bus response; interrupt outputs follow register state one edge later.
// Backpressure: none; a request every cycle is sustained.
// Ports: clk, cpurst (sync active-high), bus (slave modport), mip_mtip, mip_msip.
module clint_timer
   import clint_timer_pkg::*;
#(
   parameter int unsigned TICK_DIV = 1
) (
   input  logic         clk,
   input  logic         cpurst,
   clint_timer_if.slave bus,
   output logic         mip_mtip,
   output logic         mip_msip
);

   reg_sel_e    sel;
   logic        wr;
   logic        time_wr;
   logic        tick;
   logic [63:0] mtime;
   logic [63:0] mtimecmp;
   logic [63:0] mtime_nxt;
   logic [63:0] mtimecmp_nxt;
   logic        msip;
   logic [31:0] rd_val;
   logic        ack;
   logic        err;
   logic [31:0] rdata;

   assign sel     = decode_addr(bus.bus_addr);
   assign wr      = bus.bus_req && bus.bus_we;
   assign time_wr = wr && ((sel == SEL_TIME_LO) || (sel == SEL_TIME_HI));

   // A software write to mtime realigns the prescaler phase to the write.
   clint_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk     (clk),
      .cpurst  (cpurst),
      .restart (time_wr),
      .tick    (tick)
   );

   // Write beats tick: the written half loads, the other half holds, no increment.
   // The increment is a single 64-bit add, so the carry lands in the same edge.
   always_comb begin
      mtime_nxt = mtime;
      if (wr && (sel == SEL_TIME_LO)) begin
         mtime_nxt[31:0] = bus.bus_wdata;
      end else if (wr && (sel == SEL_TIME_HI)) begin
         mtime_nxt[63:32] = bus.bus_wdata;
      end else if (tick) begin
         mtime_nxt = mtime + 64'd1;
      end
   end

   always_comb begin
      mtimecmp_nxt = mtimecmp;
      if (wr && (sel == SEL_CMP_LO)) begin
         mtimecmp_nxt[31:0] = bus.bus_wdata;
      end else if (wr && (sel == SEL_CMP_HI)) begin
         mtimecmp_nxt[63:32] = bus.bus_wdata;
      end
   end

   // Read mux sees pre-edge state, so a read returns the value before any
   // same-cycle write or tick.
   always_comb begin
      rd_val = '0;
      unique case (sel)
         SEL_MSIP:    rd_val = {31'd0, msip};
         SEL_CMP_LO:  rd_val = mtimecmp[31:0];
         SEL_CMP_HI:  rd_val = mtimecmp[63:32];
         SEL_TIME_LO: rd_val = mtime[31:0];
         SEL_TIME_HI: rd_val = mtime[63:32];
         default:     rd_val = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (cpurst) begin
         mtime    <= '0;
         mtimecmp <= MTIMECMP_RST;
         msip     <= 1'b0;
         mip_mtip <= 1'b0;
         ack      <= 1'b0;
         err      <= 1'b0;
         rdata    <= '0;
      end else begin
         mtime    <= mtime_nxt;
         mtimecmp <= mtimecmp_nxt;
         if (wr && (sel == SEL_MSIP)) begin
            msip <= bus.bus_wdata[0];
         end
         // Compare on post-edge values so the level tracks the state just committed.
         mip_mtip <= (mtime_nxt >= mtimecmp_nxt);
         ack      <= bus.bus_req;
         err      <= bus.bus_req && (sel == SEL_NONE);
         rdata    <= (bus.bus_req && !bus.bus_we) ? rd_val : 32'd0;
      end
   end

   assign bus.bus_ack   = ack;
   assign bus.bus_err   = err;
   assign bus.bus_rdata = rdata;
   assign mip_msip      = msip;

endmodule

// File: tb/tb_clint_timer.sv
`timescale 1ns/1ps
module tb_clint_timer;

   logic clk = 1'b0;
   logic cpurst;
   logic mtip1, msip1, mtip4, msip4;

   clint_timer_if bus1 ();
   clint_timer_if bus4 ();

   clint_timer #(.TICK_DIV(1)) dut (
      .clk      (clk),
      .cpurst   (cpurst),
      .bus      (bus1),
      .mip_mtip (mtip1),
      .mip_msip (msip1)
   );

   clint_timer #(.TICK_DIV(4)) dut4 (
      .clk      (clk),
      .cpurst   (cpurst),
      .bus      (bus4),
      .mip_mtip (mtip4),
      .mip_msip (msip4)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic        is_rd;
      int          due;
   } exp_t;

   exp_t sb1[$];
   exp_t sb4[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Scoreboard side: every ack must match the oldest outstanding request,
   // arrive exactly one cycle after it, and outputs must be 0 between acks.
   always @(negedge clk) begin : mon1
      exp_t e;
      if (bus1.bus_ack === 1'b1) begin
         if (sb1.size() == 0) begin
            chk("dut1_spurious_ack", {63'd0, bus1.bus_ack}, 64'd0);
         end else begin
            e = sb1.pop_front();
            chk("dut1_ack_cycle", 64'(cyc), 64'(e.due));
            chk("dut1_err", {63'd0, bus1.bus_err}, {63'd0, e.err});
            if (e.is_rd) chk("dut1_rdata", {32'd0, bus1.bus_rdata}, {32'd0, e.rdata});
         end
      end else begin
         chk("dut1_idle_out", {31'd0, bus1.bus_err, bus1.bus_rdata}, 64'd0);
      end
   end

   always @(negedge clk) begin : mon4
      exp_t e;
      if (bus4.bus_ack === 1'b1) begin
         if (sb4.size() == 0) begin
            chk("dut4_spurious_ack", {63'd0, bus4.bus_ack}, 64'd0);
         end else begin
            e = sb4.pop_front();
            chk("dut4_ack_cycle", 64'(cyc), 64'(e.due));
            chk("dut4_err", {63'd0, bus4.bus_err}, {63'd0, e.err});
            if (e.is_rd) chk("dut4_rdata", {32'd0, bus4.bus_rdata}, {32'd0, e.rdata});
         end
      end else begin
         chk("dut4_idle_out", {31'd0, bus4.bus_err, bus4.bus_rdata}, 64'd0);
      end
   end

   // All stimulus tasks start and end at posedge+1.
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic xfer1(input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err);
      exp_t e;
      bus1.bus_req   = 1'b1;
      bus1.bus_we    = we;
      bus1.bus_addr  = addr;
      bus1.bus_wdata = wdata;
      e.rdata = exp_rd;
      e.err   = exp_err;
      e.is_rd = !we;
      e.due   = cyc + 1;
      sb1.push_back(e);
      @(posedge clk);
      #1;
      bus1.bus_req = 1'b0;
      bus1.bus_we  = 1'b0;
   endtask

   task automatic xfer4(input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd);
      exp_t e;
      bus4.bus_req   = 1'b1;
      bus4.bus_we    = we;
      bus4.bus_addr  = addr;
      bus4.bus_wdata = wdata;
      e.rdata = exp_rd;
      e.err   = 1'b0;
      e.is_rd = !we;
      e.due   = cyc + 1;
      sb4.push_back(e);
      @(posedge clk);
      #1;
      bus4.bus_req = 1'b0;
      bus4.bus_we  = 1'b0;
   endtask

   task automatic rd1(input logic [15:0] addr, input logic [31:0] exp_rd);
      xfer1(1'b0, addr, 32'd0, exp_rd, 1'b0);
   endtask

   task automatic wr1(input logic [15:0] addr, input logic [31:0] data);
      xfer1(1'b1, addr, data, 32'd0, 1'b0);
   endtask

   initial begin : watchdog
      #50000;
      $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      cpurst         = 1'b1;
      bus1.bus_req   = 1'b0;
      bus1.bus_we    = 1'b0;
      bus1.bus_addr  = 16'd0;
      bus1.bus_wdata = 32'd0;
      bus4.bus_req   = 1'b0;
      bus4.bus_we    = 1'b0;
      bus4.bus_addr  = 16'd0;
      bus4.bus_wdata = 32'd0;
      idle(5);

      // Reset state
      chk("rst_ack",   {63'd0, bus1.bus_ack}, 64'd0);
      chk("rst_err",   {63'd0, bus1.bus_err}, 64'd0);
      chk("rst_rdata", {32'd0, bus1.bus_rdata}, 64'd0);
      chk("rst_mtip",  {63'd0, mtip1}, 64'd0);
      chk("rst_msip",  {63'd0, msip1}, 64'd0);
      chk("rst_mtip4", {63'd0, mtip4}, 64'd0);
      cpurst = 1'b0;

      // Ten idle cycles after reset -> mtime = 10 in the request cycle
      idle(10);
      rd1(16'hBFF8, 32'd10);
      rd1(16'hBFFC, 32'd0);
      rd1(16'h4000, 32'hFFFF_FFFF);
      rd1(16'h4004, 32'hFFFF_FFFF);
      chk("idle_mtip", {63'd0, mtip1}, 64'd0);

      // Compare match at mtime == 20, then disarm
      wr1(16'h4004, 32'd0);
      wr1(16'hBFFC, 32'd0);
      wr1(16'hBFF8, 32'd0);          // mtime = 0 next cycle
      wr1(16'h4000, 32'd20);         // mtime = 1 afterwards
      idle(18);
      chk("mtip_at_19", {63'd0, mtip1}, 64'd0);
      idle(1);
      chk("mtip_at_20", {63'd0, mtip1}, 64'd1);
      idle(2);
      chk("mtip_level", {63'd0, mtip1}, 64'd1);
      wr1(16'h4000, 32'hFFFF_FFFF);
      chk("mtip_drop", {63'd0, mtip1}, 64'd0);

      // Carry from low to high half, and full 64-bit wrap
      wr1(16'hBFF8, 32'hFFFF_FFFF);
      wr1(16'hBFFC, 32'd0);          // write holds low half, no increment
      idle(1);
      rd1(16'hBFF8, 32'd0);
      rd1(16'hBFFC, 32'd1);
      chk("mtip_64bit_cmp", {63'd0, mtip1}, 64'd1);
      wr1(16'hBFFC, 32'hFFFF_FFFF);
      wr1(16'hBFF8, 32'hFFFF_FFFF);
      idle(1);
      rd1(16'hBFF8, 32'd0);
      rd1(16'hBFFC, 32'd0);
      chk("mtip_after_wrap", {63'd0, mtip1}, 64'd0);

      // Software interrupt bit
      wr1(16'h0000, 32'hFFFF_FFFF);
      chk("msip_set", {63'd0, msip1}, 64'd1);
      rd1(16'h0000, 32'd1);
      wr1(16'h0000, 32'd0);
      chk("msip_clr", {63'd0, msip1}, 64'd0);
      wr1(16'h0002, 32'd1);          // byte-offset bits ignored
      chk("msip_alias_set", {63'd0, msip1}, 64'd1);
      rd1(16'h0001, 32'd1);
      wr1(16'h0003, 32'd0);
      chk("msip_alias_clr", {63'd0, msip1}, 64'd0);

      // Unmapped offsets: error, zero data, no side effects
      xfer1(1'b0, 16'h1234, 32'd0, 32'd0, 1'b1);
      xfer1(1'b1, 16'h1234, 32'hDEAD_BEEF, 32'd0, 1'b1);
      xfer1(1'b1, 16'h4008, 32'h0000_0001, 32'd0, 1'b1);
      rd1(16'h4000, 32'hFFFF_FFFF);
      rd1(16'h4004, 32'd0);
      rd1(16'h0000, 32'd0);
      chk("unmapped_msip", {63'd0, msip1}, 64'd0);

      // Reset in the middle of a request with mtime = 500 and mtip high
      wr1(16'h4000, 32'd0);
      wr1(16'hBFFC, 32'd0);
      wr1(16'hBFF8, 32'd500);
      chk("mtip_pre_rst", {63'd0, mtip1}, 64'd1);
      bus1.bus_req  = 1'b1;
      bus1.bus_we   = 1'b0;
      bus1.bus_addr = 16'hBFF8;
      cpurst        = 1'b1;
      @(posedge clk);
      #1;
      bus1.bus_req = 1'b0;
      cpurst       = 1'b0;
      chk("midreq_rst_ack",  {63'd0, bus1.bus_ack}, 64'd0);
      chk("midreq_rst_mtip", {63'd0, mtip1}, 64'd0);
      rd1(16'hBFF8, 32'd0);
      rd1(16'h4000, 32'hFFFF_FFFF);
      rd1(16'h4004, 32'hFFFF_FFFF);
      rd1(16'h0000, 32'd0);
      chk("post_rst_mtip", {63'd0, mtip1}, 64'd0);

      // TICK_DIV=4: write restarts prescaler, then one increment per 4 cycles
      xfer4(1'b1, 16'hBFF8, 32'd0, 32'd0);
      for (int k = 0; k < 4; k++) begin
         idle(3);
         xfer4(1'b0, 16'hBFF8, 32'd0, 32'(k));
      end
      xfer4(1'b0, 16'hBFFC, 32'd0, 32'd0);

      idle(2);
      chk("sb1_drained", 64'(sb1.size()), 64'd0);
      chk("sb4_drained", 64'(sb4.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/clint_timer.md
CLINT_TIMER -- requirements
Module: clint_timer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1, clk cycles per mtime increment, legal range 1..65535.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port cpurst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port bus_req  input  1  access request, one-cycle qualifier.
REQ-005 SHALL have port bus_we  input  1  1 = write, 0 = read, qualified by bus_req.
REQ-006 SHALL have port bus_addr  input  16  byte offset, word-aligned; bits [1:0] ignored.
REQ-007 SHALL have port bus_wdata  input  32  write data.
REQ-008 SHALL have port bus_ack  output  1  response strobe, one cycle after each bus_req.
REQ-009 SHALL have port bus_rdata  output  32  read data, valid while bus_ack=1, else 0.
REQ-010 SHALL have port bus_err  output  1  pulses with bus_ack for an unmapped offset.
REQ-011 SHALL have port mip_mtip  output  1  timer interrupt pending, to csrfile mip_mtip.
REQ-012 SHALL have port mip_msip  output  1  software interrupt pending, to csrfile mip_msip.

Function
REQ-013 SHALL map offsets: 0x0000 msip (bit0 only; others read 0), 0x4000 mtimecmp[31:0], 0x4004 mtimecmp[63:32], 0xBFF8 mtime[31:0], 0xBFFC mtime[63:32].
REQ-014 SHALL assert bus_ack exactly one cycle after each cycle with bus_req=1; back-to-back requests get back-to-back acks; no wait states.
REQ-015 SHALL register bus_rdata from the value the register holds in the request cycle, i.e. before any same-cycle write or tick takes effect.
REQ-016 SHALL commit writes at the end of the request cycle, so a read in the next cycle returns the new value.
REQ-017 SHALL, for an unmapped offset, return bus_rdata=0, ignore the write, and assert bus_err together with bus_ack.
REQ-018 SHALL keep a 64-bit mtime that increments by 1 on each tick and wraps 0xFFFF_FFFF_FFFF_FFFF -> 0 with no flag.
REQ-019 SHALL generate one tick every TICK_DIV clk cycles from a prescaler counter running 0..TICK_DIV-1; with TICK_DIV=1 a tick occurs every cycle.
REQ-020 SHALL give a write to either mtime half priority over a same-cycle tick: the written half takes bus_wdata, the other half holds, no increment occurs, and the prescaler restarts from 0.
REQ-021 SHALL carry the low-half increment into mtime[63:32] in the same cycle; no torn carry is visible to reads.
REQ-022 SHALL drive mip_mtip as a register set to (mtime >= mtimecmp, 64-bit unsigned) using the values after each clock edge; it is level, never a pulse.
REQ-023 SHALL deassert mip_mtip on the edge after a write makes mtimecmp > mtime.
REQ-024 SHALL drive mip_msip = msip register bit0 directly, following a write on the next cycle.

Reset
REQ-025 SHALL, while cpurst=1, set mtime=0, mtimecmp=0xFFFF_FFFF_FFFF_FFFF, msip=0, prescaler=0, mip_mtip=0, bus_ack=0, bus_err=0, bus_rdata=0.
REQ-026 SHALL give cpurst priority over any same-cycle bus access or tick; an in-flight request is dropped with no ack.

Structure
REQ-027 SHALL place the five offset constants and the mtimecmp reset value in the shared CSR/peripheral package.
REQ-028 SHALL implement the prescaler as a single sub-module clint_tick_gen (inputs clk, cpurst, restart; output tick); everything else stays in clint_timer.

Verification
REQ-029 Reset, then idle for 10 cycles with TICK_DIV=1 -> read 0xBFF8 returns 10 (±0 cycles, counting from the first cycle after reset), mip_mtip=0.
REQ-030 Write 0x4004=0, then 0x4000=20 -> mip_mtip rises on the edge where mtime reaches 20; writing 0x4000=0xFFFF_FFFF then drops it on the next cycle.
REQ-031 Write 0xBFF8=0xFFFF_FFFF, 0xBFFC=0 -> after one tick, reads return 0xBFF8=0, 0xBFFC=1 (carry); 0xBFFC=0xFFFF_FFFF plus low wrap -> both halves 0.
REQ-032 Write 0x0000=0xFFFF_FFFF -> mip_msip=1 next cycle and read 0x0000 returns 0x1; write 0 -> mip_msip=0.
REQ-033 Read 0x1234 -> bus_ack=1, bus_err=1, bus_rdata=0, all registers unchanged; with TICK_DIV=4, mtime advances once every 4 cycles.
REQ-034 Assert cpurst mid-request with mtime=500 -> next cycle bus_ack=0, mtime=0, mtimecmp all ones, mip_mtip=0.
